iec_bus_frontend: RTL and testbench



---
 rtl/iec_pkg.sv | 14 +
 rtl/iec_line_filter.sv | 82 ++++++++
 rtl/iec_bus_frontend.sv | 77 +++++++
 tb/tb_iec_bus_frontend.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iec_pkg.sv
// Shared constants for the IEC serial-bus front end: default timing parameters
// and channel indices into the line vectors.
package iec_pkg;

  localparam int unsigned IEC_CHANNELS    = 3;
  localparam int unsigned IEC_SYNC_STAGES = 2;
  localparam int unsigned IEC_FILTER_LEN  = 2;
  localparam int unsigned IEC_PHI2_DIV    = 32;

  localparam int unsigned IEC_ATN  = 0;
  localparam int unsigned IEC_CLK  = 1;
  localparam int unsigned IEC_DATA = 2;

endpackage

// File: rtl/iec_line_filter.sv
// One bus line: synchroniser chain, stability counter, edge strobes and a
// sticky flag for pulses that were too short to be accepted.
module iec_line_filter
  import iec_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = IEC_SYNC_STAGES,
  parameter int unsigned FILTER_LEN  = IEC_FILTER_LEN,
  parameter logic        IDLE_LEVEL  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  input  logic glitch_clr_i,
  output logic line_o,
  output logic rise_o,
  output logic fall_o,
  output logic glitch_o
);

  localparam int unsigned    CNT_W    = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   line_q, line_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   glitch_q, glitch_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // A new level is accepted only after FILTER_LEN consecutive differing samples;
  // falling back early means the pulse was rejected.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], line_i};
    cnt_d    = cnt_q;
    line_d   = line_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = glitch_q & ~glitch_clr_i;
    if (s != line_q) begin
      if (cnt_q == CNT_LAST) begin
        line_d = s;
        cnt_d  = '0;
        rise_d = s;
        fall_d = ~s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
      if (cnt_q != '0) begin
        glitch_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= {SYNC_STAGES{IDLE_LEVEL}};
      cnt_q    <= '0;
      line_q   <= IDLE_LEVEL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      line_q   <= line_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign line_o   = line_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign glitch_o = glitch_q;

endmodule

// File: rtl/iec_bus_frontend.sv
// IEC bus input conditioner: per-line filters plus the phi2 rising/falling
// enable generator for the CPU and VIAs.
module iec_bus_frontend
  import iec_pkg::*;
#(
  parameter int unsigned CHANNELS    = IEC_CHANNELS,
  parameter int unsigned SYNC_STAGES = IEC_SYNC_STAGES,
  parameter int unsigned FILTER_LEN  = IEC_FILTER_LEN,
  parameter int unsigned DIV         = IEC_PHI2_DIV,
  parameter logic        IDLE_LEVEL  = 1'b1
) (
  input  logic                clk32,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] line_in,
  output logic [CHANNELS-1:0] line_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] glitch,
  input  logic                glitch_clr,
  input  logic                run,
  output logic                p2_r,
  output logic                p2_f
);

  localparam int unsigned      DIV_W    = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DIV / 2);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_line
    iec_line_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .IDLE_LEVEL  (IDLE_LEVEL)
    ) u_filter (
      .clk          (clk32),
      .rst_n        (reset_n),
      .line_i       (line_in[g]),
      .glitch_clr_i (glitch_clr),
      .line_o       (line_out[g]),
      .rise_o       (rise[g]),
      .fall_o       (fall[g]),
      .glitch_o     (glitch[g])
    );
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic             p2_r_q, p2_r_d;
  logic             p2_f_q, p2_f_d;

  // Divider only advances on run edges, so a stall stretches the period exactly.
  always_comb begin
    div_d  = div_q;
    p2_r_d = 1'b0;
    p2_f_d = 1'b0;
    if (run) begin
      p2_r_d = (div_q == '0);
      p2_f_d = (div_q == DIV_HALF);
      div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= '0;
      p2_r_q <= 1'b0;
      p2_f_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      p2_r_q <= p2_r_d;
      p2_f_q <= p2_f_d;
    end
  end

  assign p2_r = p2_r_q;
  assign p2_f = p2_f_q;

endmodule

// File: tb/tb_iec_bus_frontend.sv
// Scoreboard bench for iec_bus_frontend: a default instance (FILTER_LEN=2) and
// a FILTER_LEN=4 instance share clock and reset.
module tb_iec_bus_frontend;
  import iec_pkg::*;

  localparam int unsigned CH     = 3;
  localparam int unsigned IDX_W  = $clog2(CH);
  localparam int          SYNC   = 2;
  localparam int          FLEN_A = 2;
  localparam int          FLEN_B = 4;
  localparam int          DIV    = 32;
  localparam int          K_RISE = 1;
  localparam int          K_FALL = 2;

  logic          clk32 = 1'b0;
  logic          reset_n = 1'b0;
  logic [CH-1:0] line_a, line_b;
  logic [CH-1:0] line_out_a, rise_a, fall_a, glitch_a;
  logic [CH-1:0] line_out_b, rise_b, fall_b, glitch_b;
  logic          glitch_clr_a, glitch_clr_b, run_a, run_b;
  logic          p2_r_a, p2_f_a, p2_r_b, p2_f_b;

  always #5 clk32 = ~clk32;

  iec_bus_frontend u_dut_a (
    .clk32 (clk32), .reset_n (reset_n), .line_in (line_a), .line_out (line_out_a),
    .rise (rise_a), .fall (fall_a), .glitch (glitch_a), .glitch_clr (glitch_clr_a),
    .run (run_a), .p2_r (p2_r_a), .p2_f (p2_f_a)
  );

  iec_bus_frontend #(.FILTER_LEN(FLEN_B)) u_dut_b (
    .clk32 (clk32), .reset_n (reset_n), .line_in (line_b), .line_out (line_out_b),
    .rise (rise_b), .fall (fall_b), .glitch (glitch_b), .glitch_clr (glitch_clr_b),
    .run (run_b), .p2_r (p2_r_b), .p2_f (p2_f_b)
  );

  typedef struct {
    int dut;
    int ch;
    int kind;
    int cyc;
  } ev_t;

  ev_t ev_q[$];
  ev_t ph_q[$];
  int  cyc = 0;
  int  rn = 0;
  int  n_checks = 0;
  int  n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk32);
      #2;
    end
  endtask

  task automatic push_edge(input int dut, input int ch, input int kind, input int at);
    ev_q.push_back('{dut, ch, kind, at});
  endtask

  task automatic wait_strobe(input bit want_f, output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if ((want_f ? p2_f_a : p2_r_a) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check_eq(want_f ? "p2f_timeout" : "p2r_timeout", 32'(0), 32'(1));
  endtask

  always @(posedge clk32) cyc <= cyc + 1;

  // Phase reference: the n-th run edge since reset strobes p2_r at n%DIV==0, p2_f at DIV/2.
  always @(posedge clk32) begin
    if (!reset_n) begin
      rn = 0;
    end else if (run_a) begin
      if (rn % DIV == 0)           ph_q.push_back('{0, 0, K_RISE, cyc + 1});
      else if (rn % DIV == DIV / 2) ph_q.push_back('{0, 0, K_FALL, cyc + 1});
      rn++;
    end
  end

  // Output monitor: every strobe the DUTs produce must match a queued expectation.
  always @(negedge clk32) begin
    logic [1:0] obs;
    int         exp_k;
    int         idx;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < CH; c++) begin
        obs = (d == 0) ? {fall_a[IDX_W'(c)], rise_a[IDX_W'(c)]}
                       : {fall_b[IDX_W'(c)], rise_b[IDX_W'(c)]};
        idx = -1;
        for (int i = 0; i < ev_q.size(); i++)
          if (ev_q[i].dut == d && ev_q[i].ch == c && ev_q[i].cyc == cyc) idx = i;
        exp_k = 0;
        if (idx >= 0) begin
          exp_k = ev_q[idx].kind;
          ev_q.delete(idx);
        end
        if (obs != 2'b00 || exp_k != 0)
          check_eq($sformatf("edge_%s_ch%0d", (d == 0) ? "a" : "b", c), 32'(obs), 32'(exp_k));
      end
    end
    for (int i = ev_q.size() - 1; i >= 0; i--) begin
      if (ev_q[i].cyc <= cyc) begin
        check_eq($sformatf("edge_missing_%0d_ch%0d", ev_q[i].dut, ev_q[i].ch), 32'(0),
                 32'(ev_q[i].kind));
        ev_q.delete(i);
      end
    end
    while (ph_q.size() > 0 && ph_q[0].cyc < cyc) begin
      check_eq("p2_missing", 32'(0), 32'(ph_q[0].kind));
      void'(ph_q.pop_front());
    end
    exp_k = 0;
    if (ph_q.size() > 0 && ph_q[0].cyc == cyc) begin
      exp_k = ph_q[0].kind;
      void'(ph_q.pop_front());
    end
    obs = {p2_f_a, p2_r_a};
    if (obs != 2'b00 || exp_k != 0) check_eq("p2_strobe", 32'(obs), 32'(exp_k));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int s0, r1, f1, r2, cr, cf, k, rel, at;
    line_a       = '1;
    line_b       = '1;
    glitch_clr_a = 1'b0;
    glitch_clr_b = 1'b0;
    run_a        = 1'b0;
    run_b        = 1'b0;

    tick(3);
    check_eq("in_reset_line_out", 32'(line_out_a), 32'(3'b111));
    reset_n = 1'b1;
    tick(3);
    check_eq("rst_line_out_a", 32'(line_out_a), 32'(3'b111));
    check_eq("rst_line_out_b", 32'(line_out_b), 32'(3'b111));
    check_eq("rst_glitch_a", 32'(glitch_a), 32'(0));
    check_eq("rst_strobes_a", 32'({rise_a, fall_a}), 32'(0));
    check_eq("rst_p2_idle", 32'({p2_r_a, p2_f_a}), 32'(0));

    // Phase generator start-up and period
    s0 = cyc;
    run_a = 1'b1;
    wait_strobe(1'b0, r1);
    check_eq("p2r_first_latency", 32'(r1 - s0), 32'(1));
    wait_strobe(1'b1, f1);
    check_eq("p2f_after_p2r", 32'(f1 - r1), 32'(DIV / 2));
    wait_strobe(1'b0, r2);
    check_eq("p2r_period", 32'(r2 - r1), 32'(DIV));

    // DATA 1->0 accepted after SYNC+FILTER edges
    line_a[IEC_DATA] = 1'b0;
    push_edge(0, IEC_DATA, K_FALL, cyc + SYNC + FLEN_A);
    tick(6);
    check_eq("data_fall_level", 32'(line_out_a), 32'(3'b011));
    check_eq("data_fall_no_glitch", 32'(glitch_a), 32'(0));

    // ATN one-cycle pulse is rejected and flagged
    line_a[IEC_ATN] = 1'b0;
    tick(1);
    line_a[IEC_ATN] = 1'b1;
    tick(4);
    check_eq("atn_pulse_level", 32'(line_out_a), 32'(3'b011));
    check_eq("atn_glitch_set", 32'(glitch_a), 32'(3'b001));
    tick(3);
    check_eq("atn_glitch_sticky", 32'(glitch_a), 32'(3'b001));
    glitch_clr_a = 1'b1;
    tick(1);
    glitch_clr_a = 1'b0;
    check_eq("atn_glitch_clr", 32'(glitch_a), 32'(0));

    // New glitch landing on the same edge as glitch_clr must survive
    line_a[IEC_ATN] = 1'b0;
    tick(1);
    line_a[IEC_ATN] = 1'b1;
    tick(2);
    check_eq("coinc_before", 32'(glitch_a), 32'(0));
    glitch_clr_a = 1'b1;
    tick(1);
    glitch_clr_a = 1'b0;
    check_eq("coinc_set_wins", 32'(glitch_a), 32'(3'b001));
    glitch_clr_a = 1'b1;
    tick(1);
    glitch_clr_a = 1'b0;
    check_eq("coinc_cleared", 32'(glitch_a), 32'(0));

    // Stall run for 10 cycles mid-period
    wait_strobe(1'b0, cr);
    tick(4);
    run_a = 1'b0;
    tick(10);
    run_a = 1'b1;
    wait_strobe(1'b1, cf);
    check_eq("stall_p2f_delay", 32'(cf - cr), 32'(DIV / 2 + 10));
    wait_strobe(1'b0, at);
    check_eq("stall_p2r_spacing", 32'(at - cf), 32'(DIV / 2));

    // FILTER_LEN=4: 3-cycle CLK pulse rejected, 4-cycle pulse accepted
    line_b[IEC_CLK] = 1'b0;
    tick(3);
    line_b[IEC_CLK] = 1'b1;
    tick(8);
    check_eq("b_short_level", 32'(line_out_b), 32'(3'b111));
    check_eq("b_short_glitch", 32'(glitch_b), 32'(3'b010));
    line_b[IEC_CLK] = 1'b0;
    push_edge(1, IEC_CLK, K_FALL, cyc + SYNC + FLEN_B);
    tick(4);
    line_b[IEC_CLK] = 1'b1;
    push_edge(1, IEC_CLK, K_RISE, cyc + SYNC + FLEN_B);
    tick(12);
    check_eq("b_long_level", 32'(line_out_b), 32'(3'b111));
    check_eq("b_long_glitch", 32'(glitch_b), 32'(3'b010));

    // Reset while a CLK transition is pending (cnt=1)
    k = cyc;
    line_a[IEC_CLK] = 1'b0;
    tick(3);
    check_eq("pending_level", 32'(line_out_a), 32'(3'b011));
    reset_n = 1'b0;
    #1;
    check_eq("midrst_line_out", 32'(line_out_a), 32'(3'b111));
    check_eq("midrst_strobes", 32'({rise_a, fall_a, p2_r_a, p2_f_a}), 32'(0));
    check_eq("midrst_glitch_b", 32'(glitch_b), 32'(0));
    tick(2);
    reset_n = 1'b1;
    rel = cyc;
    push_edge(0, IEC_CLK, K_FALL, rel + SYNC + FLEN_A);
    push_edge(0, IEC_DATA, K_FALL, rel + SYNC + FLEN_A);
    wait_strobe(1'b0, at);
    check_eq("postrst_p2r_latency", 32'(at - rel), 32'(1));
    tick(8);
    check_eq("postrst_level", 32'(line_out_a), 32'(3'b001));
    check_eq("postrst_glitch", 32'(glitch_a), 32'(0));
    check_eq("postrst_elapsed", 32'(cyc - k > 0), 32'(1));

    tick(4);
    check_eq("edge_queue_empty", 32'(ev_q.size()), 32'(0));
    check_eq("b_no_phase", 32'({p2_r_b, p2_f_b}), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
